// File: rtl/plot_sink.sv
// plot_sink: linearises drawing-engine plots, queues them and drains them to a framebuffer port.
// Define PLOT_SINK_CLIP_EN to drop and count plots outside WIDTH x HEIGHT.
module plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_x,
    input  logic [6:0]        in_y,
    input  logic [2:0]        in_colour,
    input  logic              plot,
    output logic              full,
    input  logic              clear,
    input  logic [2:0]        clear_colour,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_data,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              clearing,
    output logic              clear_done,
    output logic              overflow,
    output logic [7:0]        clip_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + 3;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [EW-1:0]     fifo_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic [1:0]        state_q, state_d;
    logic              pending_q, pending_d;
    logic [2:0]        colour_q, colour_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              clipped;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [EW-1:0]     head;

`ifdef PLOT_SINK_CLIP_EN
    logic [7:0] clip_q, clip_d;

    assign clipped = (32'(in_x) >= WIDTH) || (32'(in_y) >= HEIGHT);

    always_comb begin
        clip_d = clip_q;
        if (plot && clipped && clip_q != 8'hff) clip_d = clip_q + 8'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) clip_q <= '0;
        else       clip_q <= clip_d;
    end

    assign clip_count = clip_q;
`else
    assign clipped    = 1'b0;
    assign clip_count = '0;
`endif

    // Address arithmetic wraps at ADDR_W, matching the framebuffer width.
    assign push_addr = ADDR_W'(in_y) * ADDR_W'(WIDTH) + ADDR_W'(in_x);
    assign head      = fifo_q[rd_ptr_q];
    assign push      = plot && !full_q && !clipped;
    assign pop       = (state_q == S_WRITE) && mem_ready;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        full_d     = (count_d == CW'(DEPTH));
        overflow_d = overflow_q | (plot && full_q && !clipped);
        pending_d  = pending_q | clear;
        colour_d   = clear ? clear_colour : colour_q;
        state_d    = state_q;
        fill_d     = fill_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q)          state_d = S_CLEAR;
                else if (count_q != '0) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (pending_q)          state_d = S_CLEAR;
                    else if (count_d != '0) state_d = S_WRITE;
                    else                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (mem_ready) begin
                    if (fill_q == LAST) begin
                        fill_d    = '0;
                        done_d    = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        fill_d = fill_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr_q] <= {push_addr, in_colour};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            state_q    <= S_IDLE;
            pending_q  <= 1'b0;
            colour_q   <= '0;
            fill_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            state_q    <= state_d;
            pending_q  <= pending_d;
            colour_q   <= colour_d;
            fill_q     <= fill_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        if (state_q == S_WRITE) begin
            {mem_addr, mem_data} = head;
        end else if (state_q == S_CLEAR) begin
            mem_addr = fill_q;
            mem_data = colour_q;
        end
    end

    assign mem_we     = (state_q == S_WRITE) || (state_q == S_CLEAR);
    assign clearing   = (state_q == S_CLEAR);
    assign clear_done = done_q;
    assign full       = full_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: vector table, hand-built corner sequences and a randomized
// scoreboard run against a queue-based model of the plot sink.
module tb_plot_sink;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int DEPTH  = 16;
    localparam int NPIX   = WIDTH * HEIGHT;

`ifdef PLOT_SINK_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        plot;
    logic        full;
    logic        clear;
    logic [2:0]  clear_colour;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        clearing;
    logic        clear_done;
    logic        overflow;
    logic [7:0]  clip_count;

    plot_sink dut (
        .clock(clock), .reset(reset),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .plot(plot),
        .full(full), .clear(clear), .clear_colour(clear_colour),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_ready(mem_ready), .clearing(clearing),
        .clear_done(clear_done), .overflow(overflow),
        .clip_count(clip_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic        we;
        logic [14:0] addr;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic single_plot(input vec_t v, input int idx);
        mem_ready = 1'b1;
        in_x = v.x; in_y = v.y; in_colour = v.c; plot = 1'b1;
        tick();
        plot = 1'b0;
        chk($sformatf("vec%0d_we_c1", idx), mem_we, 0);
        tick();
        chk($sformatf("vec%0d_we_c2", idx), mem_we, v.we);
        if (v.we) begin
            chk($sformatf("vec%0d_addr", idx), mem_addr, v.addr);
            chk($sformatf("vec%0d_data", idx), mem_data, v.c);
        end
        tick();
        chk($sformatf("vec%0d_we_c3", idx), mem_we, 0);
        tick();
    endtask

    function automatic logic [17:0] clr_exp(input int idx);
        if (idx == 0)        return {15'd161, 3'd1};
        if (idx <= NPIX)     return {15'(idx - 1), 3'd2};
        if (idx == NPIX + 1) return {15'd162, 3'd3};
        if (idx == NPIX + 2) return {15'd163, 3'd4};
        return {15'd164, 3'd7};
    endfunction

    initial begin
        vec_t        vecs [7];
        logic [17:0] q [$];
        logic [17:0] got;
        logic [14:0] prev_addr;
        logic [2:0]  prev_data;
        logic        prev_we, prev_rdy;
        int nw, bad, stall_bad, found, cyc, extra, done_cnt, done_cyc;
        int last_cyc, done_clr, d_sent, full_err, wr_err, ovf_m, clip_m;
        int thr, ax;
        bit ef, cl;

        vecs[0] = '{8'd3,   7'd2,   3'd5, 1'b1,  15'd323};
        vecs[1] = '{8'd0,   7'd0,   3'd0, 1'b1,  15'd0};
        vecs[2] = '{8'd159, 7'd119, 3'd7, 1'b1,  15'd19199};
        vecs[3] = '{8'd160, 7'd0,   3'd1, !CLIP, 15'd160};
        vecs[4] = '{8'd0,   7'd1,   3'd4, 1'b1,  15'd160};
        vecs[5] = '{8'd255, 7'd127, 3'd3, !CLIP, 15'd20575};
        vecs[6] = '{8'd0,   7'd120, 3'd6, !CLIP, 15'd19200};

        reset = 1'b1; plot = 1'b0; clear = 1'b0; mem_ready = 1'b0;
        in_x = '0; in_y = '0; in_colour = '0; clear_colour = '0;
        tick(); tick();
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_full", full, 0);
        chk("rst_clearing", clearing, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_clip_count", clip_count, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) single_plot(vecs[i], i);
        chk("clip_count_table", clip_count, CLIP ? 3 : 0);

        // Overflow: 17 plots into a stalled sink
        mem_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_x = 8'(i); in_y = 7'(i); in_colour = 3'(i); plot = 1'b1;
            tick();
            if (i == 14) chk("ovf_full_15", full, 0);
            if (i == 15) chk("ovf_full_16", full, 1);
        end
        plot = 1'b0;
        chk("ovf_flag", overflow, 1);
        mem_ready = 1'b1;
        nw = 0; bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (mem_we && mem_ready) begin
                if (nw < 16 && {mem_addr, mem_data} !== {15'(161 * nw), 3'(nw)})
                    bad++;
                nw++;
            end
            tick();
        end
        chk("ovf_writes", nw, 16);
        chk("ovf_order_errs", bad, 0);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_full_after", full, 0);

        // Reset in the middle of a clear
        clear = 1'b1; clear_colour = 3'd5; tick();
        clear = 1'b0;
        found = 0;
        for (int k = 0; k < 6000 && found == 0; k++) begin
            if (clearing && mem_addr == 15'd5000) found = 1;
            else tick();
        end
        chk("rst_mid_reach", found, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_clearing", clearing, 0);
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_full", full, 0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_we || clear_done) bad++;
            tick();
        end
        chk("rst_mid_quiet", bad, 0);

        // Stalled handshake with 4 queued entries
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_x = 8'(10 + i); in_y = 7'd3; in_colour = 3'(i + 1); plot = 1'b1;
            tick();
        end
        plot = 1'b0;
        nw = 0; bad = 0; stall_bad = 0; prev_we = 1'b0; prev_rdy = 1'b1;
        prev_addr = '0; prev_data = '0;
        for (int k = 0; k < 30; k++) begin
            mem_ready = k[0];
            if (prev_we && !prev_rdy &&
                !(mem_we && mem_addr == prev_addr && mem_data == prev_data))
                stall_bad++;
            if (mem_we && mem_ready) begin
                if (nw < 4 && {mem_addr, mem_data} !== {15'(490 + nw), 3'(nw + 1)})
                    bad++;
                nw++;
            end
            prev_we = mem_we; prev_rdy = mem_ready;
            prev_addr = mem_addr; prev_data = mem_data;
            tick();
        end
        chk("stall_stable_errs", stall_bad, 0);
        chk("stall_writes", nw, 4);
        chk("stall_order_errs", bad, 0);

        // Clear requested with three plots queued behind a stalled write
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_x = 8'(1 + i); in_y = 7'd1; in_colour = (i == 0) ? 3'd1 : 3'(i + 2);
            plot = 1'b1;
            tick();
        end
        plot = 1'b0;
        clear = 1'b1; clear_colour = 3'd2; tick();
        clear = 1'b0; clear_colour = 3'd6;
        tick();
        mem_ready = 1'b1;
        nw = 0; bad = 0; cyc = 0; extra = 0; done_cnt = 0; done_cyc = -1;
        last_cyc = -9; done_clr = 0; d_sent = 0;
        while (cyc < NPIX + 400 && extra < 4) begin
            plot = 1'b0;
            if (clearing && d_sent == 0 && mem_addr == 15'd100) begin
                in_x = 8'd4; in_y = 7'd1; in_colour = 3'd7; plot = 1'b1;
                d_sent = 1;
            end
            if (clear_done) begin
                done_cnt++; done_cyc = cyc; done_clr = clearing;
            end
            if (mem_we && mem_ready) begin
                if ({mem_addr, mem_data} !== clr_exp(nw)) begin
                    if (bad == 0)
                        $display("first clear-stream deviation at write %0d: got %0d/%0d",
                                 nw, mem_addr, mem_data);
                    bad++;
                end
                if (nw == NPIX) last_cyc = cyc;
                nw++;
            end
            tick();
            cyc++;
            if (nw >= NPIX + 4) extra++;
        end
        plot = 1'b0;
        chk("clr_writes", nw, NPIX + 4);
        chk("clr_order_errs", bad, 0);
        chk("clr_done_pulses", done_cnt, 1);
        chk("clr_done_timing", done_cyc, last_cyc + 1);
        chk("clr_done_clearing_low", done_clr, 0);
        chk("clr_plot_during", d_sent, 1);

        // Randomized traffic against a queue model
        q = {}; full_err = 0; wr_err = 0; ovf_m = 0; clip_m = 0;
        for (int k = 0; k < 3000; k++) begin
            thr = ((k / 300) % 2 == 1) ? 1 : 3;
            ef = (q.size() == DEPTH);
            if (full !== ef) full_err++;
            mem_ready = ($urandom_range(0, 3) < thr);
            if (mem_we && mem_ready) begin
                if (q.size() == 0) begin
                    wr_err++;
                end else begin
                    got = q.pop_front();
                    if ({mem_addr, mem_data} !== got) wr_err++;
                end
            end
            plot = $urandom_range(0, 1);
            in_x = 8'($urandom_range(0, 255));
            in_y = 7'($urandom_range(0, 127));
            in_colour = 3'($urandom_range(0, 7));
            if (plot) begin
                cl = CLIP && (in_x >= WIDTH || in_y >= HEIGHT);
                if (cl) begin
                    if (clip_m < 255) clip_m++;
                end else if (ef) begin
                    ovf_m = 1;
                end else begin
                    ax = (int'(in_y) * WIDTH + int'(in_x)) % 32768;
                    q.push_back({15'(ax), in_colour});
                end
            end
            tick();
        end
        plot = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (mem_we) begin
                if (q.size() == 0) begin
                    wr_err++;
                end else begin
                    got = q.pop_front();
                    if ({mem_addr, mem_data} !== got) wr_err++;
                end
            end
            tick();
        end
        chk("rand_full_errs", full_err, 0);
        chk("rand_write_errs", wr_err, 0);
        chk("rand_left_in_model", q.size(), 0);
        chk("rand_idle_we", mem_we, 0);
        chk("rand_overflow", overflow, ovf_m);
        chk("rand_clip_count", clip_count, clip_m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
